storage_loader: RTL
===================

Name: storage_loader

Overview:
- Host-side front end that produces the write transactions consumed by the data path's storage write interfaces: code, input, label and weight.
- Accepts a byte stream with a valid/ready handshake and parses a fixed packet header. It then issues one single-cycle write strobe per payload word, with layer and row indices auto-incremented.
- Sits between the host link (UART/JTAG bridge FIFO) and the data path.
- Also pulses the matrix storage locator reset at the start of each packet.

Parameters:
- DATA_WIDTH, 48, width of input, label and weight data words.
- INDEX_WIDTH, 32, width of layer and row indices and of the code line number.
- CODE_WIDTH, 12, width of a code storage word.
- COUNT_WIDTH, 16, width of the payload word count field.

Ports:
- clk_clk  in  1  single clock; all logic rises on it.
- reset_reset_n  in  1  synchronous, active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  byte valid.
- in_ready  out  1  loader can accept a byte this cycle.
- wr_layer_index  out  INDEX_WIDTH  layer index for input, label and weight writes.
- wr_row_index  out  INDEX_WIDTH  row index; also the code write line.
- wr_data  out  DATA_WIDTH  write data; code writes use the low CODE_WIDTH bits.
- code_is_write, input_is_write, label_is_write, weight_is_write  out  1 each  one-hot write strobes.
- locator_reset  out  1  one-cycle pulse when a valid target byte is accepted.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when a packet completes.
- err  out  1  one-cycle pulse when a byte is rejected.

Behaviour:
- Handshake: a byte transfers when in_valid and in_ready are both high on a rising edge. in_ready is high in IDLE, HDR and DATA, and low in WRITE.
- Packet format (all fields big-endian):
  - byte 0: target (0 = code, 1 = input, 2 = label, 3 = weight).
  - bytes 1-4: layer index.
  - bytes 5-8: start row.
  - bytes 9-10: word count N.
  - payload: N words. Each word is 6 bytes for input/label/weight and 2 bytes for code.
- Code words: the low 12 bits of the 2-byte word are used; upper bits are ignored. The layer field is received but does not affect code writes.
- State: IDLE.
  - Target byte 0-3: latch the target, pulse locator_reset next cycle, go to HDR with byte counter = 0.
  - Target byte greater than 3: consume the byte, pulse err, stay in IDLE.
- State: HDR.
  - Shift in 10 bytes.
  - After byte 10: if N = 0, pulse done and go to IDLE; otherwise go to DATA.
- State: DATA.
  - Shift bytes into the word register.
  - When the last byte of a word is accepted, go to WRITE.
- State: WRITE (exactly one cycle).
  - Exactly one target strobe is high.
  - wr_layer_index, wr_row_index and wr_data are valid in the same cycle.
  - Then row increments by 1 (wrapping modulo 2^INDEX_WIDTH) and the remaining count decrements.
  - If the remaining count reaches 0: pulse done in the cycle after WRITE and go to IDLE. Otherwise return to DATA.
- Latency: the write strobe is asserted one cycle after the final byte of a word is accepted. Sustained throughput is one word per (bytes-per-word + 1) cycles.
- in_valid low mid-packet stalls the parser indefinitely; there is no timeout.
- wr_* buses hold their last values outside WRITE. Strobes are low outside WRITE.
- Reset (synchronous, active-low, any state, including mid-packet):
  - state returns to IDLE; all strobes, locator_reset, done, err and busy are 0.
  - wr_layer_index, wr_row_index and wr_data are 0; counters are 0.
  - in_ready is 0 while reset is asserted and 1 in the first cycle after release.
  - A partial packet is discarded.
- A start row near the maximum wraps: start row 0xFFFFFFFF with N = 2 writes rows 0xFFFFFFFF, then 0x00000000.

Decomposition:
- Shared package storage_pkg holds:
  - the target enum (TGT_CODE = 0, TGT_INPUT = 1, TGT_LABEL = 2, TGT_WEIGHT = 3);
  - the header length constant (10);
  - the per-target word byte counts (6, and 2 for code);
  - the FSM state typedef.
- One natural sub-module, byte_shift_assembler: an 8-bit to 48-bit big-endian shift register with byte counter, load-clear and word-complete flag. It is shared by HDR and DATA.

Test Plan:
- Weight packet: layer 2, row 5, N = 2, words 0x000000010000 and 0xFFFFFFFFFFFF, in_valid held high → weight_is_write high for 2 separate cycles, carrying (2, 5, 0x000000010000) then (2, 6, 0xFFFFFFFFFFFF); locator_reset pulses once; done pulses once.
- Code packet: row 10, N = 3, words 0xF123, 0x0456, 0x0789 → code_is_write on lines 10, 11, 12 with wr_data low 12 bits 0x123, 0x456, 0x789.
- Bad target byte 0x07, then a valid input packet with N = 0 → err pulses once, no strobes; then locator_reset, done, and no input_is_write.
- Random in_valid gaps (50% duty) on a label packet with N = 4 → identical strobe sequence to the gap-free run; in_ready is low during every WRITE cycle.
- reset_reset_n low for 1 cycle after 3 payload bytes → no strobe issued, busy = 0, in_ready = 1 in the first cycle after release; the following full packet loads correctly.
- Start row 0xFFFFFFFF, N = 2 → rows 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/storage_pkg.sv
// Shared types and constants for the storage loader: write targets, FSM states
// and per-target word sizes.
package storage_pkg;

  localparam int unsigned HDR_BYTES       = 10;
  localparam int unsigned DATA_WORD_BYTES = 6;
  localparam int unsigned CODE_WORD_BYTES = 2;
  localparam int unsigned BCNT_WIDTH      = 4;

  typedef enum logic [1:0] {
    TGT_CODE   = 2'd0,
    TGT_INPUT  = 2'd1,
    TGT_LABEL  = 2'd2,
    TGT_WEIGHT = 2'd3
  } target_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_DATA  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Payload bytes per word for a given target.
  function automatic logic [BCNT_WIDTH-1:0] word_bytes(input target_e tgt);
    return (tgt == TGT_CODE) ? BCNT_WIDTH'(CODE_WORD_BYTES) : BCNT_WIDTH'(DATA_WORD_BYTES);
  endfunction

endpackage

// File: rtl/byte_shift_assembler.sv
// Big-endian byte-to-word shift register with byte counter; flags the byte that
// completes a word of 'len' bytes and exposes the word including that byte.
module byte_shift_assembler
  import storage_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [7:0]            byte_in,
  input  logic [BCNT_WIDTH-1:0] len,
  output logic [BCNT_WIDTH-1:0] count,
  output logic [WORD_WIDTH-1:0] word_next_c,
  output logic                  complete_c
);

  // Only the bytes that can still reach the output window are kept.
  logic [WORD_WIDTH-9:0] word_q;

  assign word_next_c = {word_q, byte_in};
  assign complete_c  = shift_en && (count == BCNT_WIDTH'(len - BCNT_WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      count  <= '0;
    end else if (clear) begin
      word_q <= '0;
      count  <= '0;
    end else if (shift_en) begin
      word_q <= complete_c ? '0 : word_next_c[WORD_WIDTH-9:0];
      count  <= complete_c ? '0 : BCNT_WIDTH'(count + BCNT_WIDTH'(1));
    end
  end

endmodule

// File: rtl/storage_loader.sv
// Host byte-stream packet parser producing single-cycle storage write strobes
// with auto-incrementing row index.
module storage_loader
  import storage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 48,
  parameter int unsigned INDEX_WIDTH = 32,
  parameter int unsigned CODE_WIDTH  = 12,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [INDEX_WIDTH-1:0] wr_layer_index,
  output logic [INDEX_WIDTH-1:0] wr_row_index,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   code_is_write,
  output logic                   input_is_write,
  output logic                   label_is_write,
  output logic                   weight_is_write,
  output logic                   locator_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_e                  state_q, state_d;
  target_e                 target_q, target_d;
  logic [INDEX_WIDTH-1:0]  layer_q, layer_d;
  logic [INDEX_WIDTH-1:0]  row_q, row_d;
  logic [COUNT_WIDTH-1:0]  remain_q, remain_d;
  logic [INDEX_WIDTH-1:0]  wr_layer_d, wr_row_d;
  logic [DATA_WIDTH-1:0]   wr_data_d;
  logic                    code_d, input_d, label_d, weight_d;
  logic                    locator_d, done_d, err_d;

  logic                    take;
  logic                    asm_shift;
  logic                    asm_clear;
  logic [BCNT_WIDTH-1:0]   asm_len;
  logic [BCNT_WIDTH-1:0]   asm_count;
  logic [DATA_WIDTH-1:0]   asm_word;
  logic                    asm_done;

  // Ready is a pure state decode, forced low while reset is held.
  assign in_ready  = reset_reset_n && (state_q != ST_WRITE);
  assign take      = in_valid && in_ready;
  assign asm_shift = take && ((state_q == ST_HDR) || (state_q == ST_DATA));
  assign asm_clear = take && (state_q == ST_IDLE);
  assign asm_len   = (state_q == ST_HDR) ? BCNT_WIDTH'(HDR_BYTES) : word_bytes(target_q);

  byte_shift_assembler #(
    .WORD_WIDTH (DATA_WIDTH)
  ) u_asm (
    .clk         (clk_clk),
    .rst_n       (reset_reset_n),
    .clear       (asm_clear),
    .shift_en    (asm_shift),
    .byte_in     (in_data),
    .len         (asm_len),
    .count       (asm_count),
    .word_next_c (asm_word),
    .complete_c  (asm_done)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    layer_d    = layer_q;
    row_d      = row_q;
    remain_d   = remain_q;
    wr_layer_d = wr_layer_index;
    wr_row_d   = wr_row_index;
    wr_data_d  = wr_data;
    code_d     = 1'b0;
    input_d    = 1'b0;
    label_d    = 1'b0;
    weight_d   = 1'b0;
    locator_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          if (in_data <= 8'd3) begin
            target_d  = target_e'(in_data[1:0]);
            locator_d = 1'b1;
            state_d   = ST_HDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_HDR: begin
        // Layer bytes have left the window by header end, so grab them after byte 4.
        if (asm_shift && (asm_count == BCNT_WIDTH'(3))) begin
          layer_d = asm_word[INDEX_WIDTH-1:0];
        end
        if (asm_done) begin
          row_d    = asm_word[INDEX_WIDTH+COUNT_WIDTH-1:COUNT_WIDTH];
          remain_d = asm_word[COUNT_WIDTH-1:0];
          if (asm_word[COUNT_WIDTH-1:0] == '0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (asm_done) begin
          wr_layer_d = layer_q;
          wr_row_d   = row_q;
          wr_data_d  = (target_q == TGT_CODE) ? DATA_WIDTH'(asm_word[CODE_WIDTH-1:0]) : asm_word;
          code_d     = (target_q == TGT_CODE);
          input_d    = (target_q == TGT_INPUT);
          label_d    = (target_q == TGT_LABEL);
          weight_d   = (target_q == TGT_WEIGHT);
          state_d    = ST_WRITE;
        end
      end

      ST_WRITE: begin
        row_d    = INDEX_WIDTH'(row_q + INDEX_WIDTH'(1));
        remain_d = COUNT_WIDTH'(remain_q - COUNT_WIDTH'(1));
        if (remain_q == COUNT_WIDTH'(1)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q         <= ST_IDLE;
      target_q        <= TGT_CODE;
      layer_q         <= '0;
      row_q           <= '0;
      remain_q        <= '0;
      wr_layer_index  <= '0;
      wr_row_index    <= '0;
      wr_data         <= '0;
      code_is_write   <= 1'b0;
      input_is_write  <= 1'b0;
      label_is_write  <= 1'b0;
      weight_is_write <= 1'b0;
      locator_reset   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      state_q         <= state_d;
      target_q        <= target_d;
      layer_q         <= layer_d;
      row_q           <= row_d;
      remain_q        <= remain_d;
      wr_layer_index  <= wr_layer_d;
      wr_row_index    <= wr_row_d;
      wr_data         <= wr_data_d;
      code_is_write   <= code_d;
      input_is_write  <= input_d;
      label_is_write  <= label_d;
      weight_is_write <= weight_d;
      locator_reset   <= locator_d;
      busy            <= (state_d != ST_IDLE);
      done            <= done_d;
      err             <= err_d;
    end
  end

endmodule
